prog_mem: RTL and testbench



---
 rtl/prog_mem.sv | 114 +++++++++++
 tb/tb_prog_mem.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_mem.sv
// Loadable program memory: a program is streamed in word by word, committed with
// load_done, then read back with one-cycle latency. prog_len masks out stale words.
module prog_mem #(
    parameter int                DATA_W    = 13,
    parameter int                DEPTH     = 128,
    parameter int                ADDR_W    = 8,
    parameter logic [DATA_W-1:0] HALT_WORD = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              load_done,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_oob,
    output logic [ADDR_W:0]   prog_len,
    output logic              prog_ready,
    output logic              overflow,
    output logic [1:0]        dbg_state
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_READY = 2'd2
    } state_t;

    state_t              r_state;
    logic [ADDR_W:0]     r_ptr;
    logic [ADDR_W:0]     r_prog_len;
    logic                r_overflow;
    logic                r_rd_valid;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_rd_oob;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_wr_ready;
    logic                w_wr_fire;
    logic [ADDR_W:0]     w_ptr_inc;
    logic                w_rd_hit;

    // Write handshake: a word moves only on a cycle where wr_valid and wr_ready are
    // both high; wr_ready never depends on wr_valid. load_start suppresses the write.
    assign w_wr_ready = (r_state == S_LOAD) && (r_ptr < DEPTH_V);
    assign w_wr_fire  = w_wr_ready && wr_valid && !load_start;
    assign w_ptr_inc  = r_ptr + 1'b1;
    // A load_start seen in READY already hides the old program from that cycle's read.
    assign w_rd_hit   = (r_state == S_READY) && !load_start && ({1'b0, rd_addr} < r_prog_len);

    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[r_ptr[IDX_W-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_prog_len <= '0;
            r_overflow <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= HALT_WORD;
            r_rd_oob   <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                if (w_rd_hit) begin
                    r_rd_data <= r_mem[rd_addr[IDX_W-1:0]];
                    r_rd_oob  <= 1'b0;
                end else begin
                    r_rd_data <= HALT_WORD;
                    r_rd_oob  <= 1'b1;
                end
            end

            if (load_start) begin
                r_state    <= S_LOAD;
                r_ptr      <= '0;
                r_prog_len <= '0;
                r_overflow <= 1'b0;
            end else if (r_state == S_LOAD) begin
                if (w_wr_fire) begin
                    r_ptr <= w_ptr_inc;
                end
                if (wr_valid && !w_wr_ready) begin
                    r_overflow <= 1'b1;
                end
                if (load_done) begin
                    r_state    <= S_READY;
                    r_prog_len <= w_wr_fire ? w_ptr_inc : r_ptr;
                end
            end
        end
    end

    assign wr_ready   = w_wr_ready;
    assign rd_valid   = r_rd_valid;
    assign rd_data    = r_rd_data;
    assign rd_oob     = r_rd_oob;
    assign prog_len   = r_prog_len;
    assign prog_ready = (r_state == S_READY);
    assign overflow   = r_overflow;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_prog_mem.sv
// Directed bench for prog_mem with DEPTH=4: load/read, bounds, overflow,
// same-cycle control events, reload and reset in the middle of a load.
module tb_prog_mem;

    localparam int DATA_W = 13;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 3;
    localparam logic [DATA_W-1:0] HALT = 13'h0000;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              load_start = 1'b0;
    logic              wr_valid = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_ready;
    logic              load_done = 1'b0;
    logic              rd_en = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_oob;
    logic [ADDR_W:0]   prog_len;
    logic              prog_ready;
    logic              overflow;
    logic [1:0]        dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    prog_mem #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .HALT_WORD(HALT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_start(load_start),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .load_done (load_done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_oob    (rd_oob),
        .prog_len  (prog_len),
        .prog_ready(prog_ready),
        .overflow  (overflow),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are observed on the next falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic push(input logic [DATA_W-1:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic finish_load();
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
    endtask

    task automatic issue_read(input logic [ADDR_W-1:0] a);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_checks++; if (dbg_state !== ST_IDLE) begin n_errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
        n_checks++; if (prog_len !== 4'd0) begin n_errors++; $display("FAIL reset_prog_len: got %0d expected 0", prog_len); end
        n_checks++; if (prog_ready !== 1'b0) begin n_errors++; $display("FAIL reset_prog_ready: got %b expected 0", prog_ready); end
        n_checks++; if (wr_ready !== 1'b0) begin n_errors++; $display("FAIL reset_wr_ready: got %b expected 0", wr_ready); end
        n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        n_checks++; if (rd_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        n_checks++; if (rd_data !== HALT) begin n_errors++; $display("FAIL reset_rd_data: got %h expected %h", rd_data, HALT); end
        n_checks++; if (rd_oob !== 1'b0) begin n_errors++; $display("FAIL reset_rd_oob: got %b expected 0", rd_oob); end
    endtask

    task automatic test_idle_read();
        wr_valid = 1'b1; wr_data = 13'h1111; load_done = 1'b1;
        rd_en = 1'b1; rd_addr = 3'd0;
        tick();
        wr_valid = 1'b0; load_done = 1'b0; rd_en = 1'b0;
        n_checks++; if (dbg_state !== ST_IDLE) begin n_errors++; $display("FAIL idle_ignores_inputs: state %0d expected %0d", dbg_state, ST_IDLE); end
        n_checks++; if (rd_valid !== 1'b1) begin n_errors++; $display("FAIL idle_rd_valid: got %b expected 1", rd_valid); end
        n_checks++; if (rd_data !== HALT) begin n_errors++; $display("FAIL idle_rd_data: got %h expected %h", rd_data, HALT); end
        n_checks++; if (rd_oob !== 1'b1) begin n_errors++; $display("FAIL idle_rd_oob: got %b expected 1", rd_oob); end
        tick();
        n_checks++; if (rd_valid !== 1'b0) begin n_errors++; $display("FAIL idle_rd_valid_drop: got %b expected 0", rd_valid); end
    endtask

    task automatic test_load_read();
        logic [DATA_W-1:0] words [3];
        words[0] = 13'h0201; words[1] = 13'h0432; words[2] = 13'h0200;
        start_load();
        n_checks++; if (wr_ready !== 1'b1) begin n_errors++; $display("FAIL load_wr_ready: got %b expected 1", wr_ready); end
        n_checks++; if (dbg_state !== ST_LOAD) begin n_errors++; $display("FAIL load_state: got %0d expected %0d", dbg_state, ST_LOAD); end
        for (int i = 0; i < 3; i++) push(words[i]);
        finish_load();
        n_checks++; if (prog_len !== 4'd3) begin n_errors++; $display("FAIL load_prog_len: got %0d expected 3", prog_len); end
        n_checks++; if (prog_ready !== 1'b1) begin n_errors++; $display("FAIL load_prog_ready: got %b expected 1", prog_ready); end
        n_checks++; if (wr_ready !== 1'b0) begin n_errors++; $display("FAIL ready_wr_ready: got %b expected 0", wr_ready); end
        for (int i = 0; i < 3; i++) begin
            issue_read(3'(i));
            n_checks++; if (rd_valid !== 1'b1 || rd_data !== words[i] || rd_oob !== 1'b0) begin
                n_errors++; $display("FAIL read_addr%0d: got v=%b d=%h oob=%b expected v=1 d=%h oob=0", i, rd_valid, rd_data, rd_oob, words[i]);
            end
        end
        issue_read(3'd3);
        n_checks++; if (rd_valid !== 1'b1 || rd_data !== HALT || rd_oob !== 1'b1) begin
            n_errors++; $display("FAIL read_past_len: got v=%b d=%h oob=%b expected v=1 d=%h oob=1", rd_valid, rd_data, rd_oob, HALT);
        end
        issue_read(3'd7);
        n_checks++; if (rd_data !== HALT || rd_oob !== 1'b1) begin
            n_errors++; $display("FAIL read_past_depth: got d=%h oob=%b expected d=%h oob=1", rd_data, rd_oob, HALT);
        end
    endtask

    task automatic test_overflow();
        logic [DATA_W-1:0] words [5];
        words[0] = 13'h0A01; words[1] = 13'h0B02; words[2] = 13'h0C03; words[3] = 13'h1D04; words[4] = 13'h1E05;
        start_load();
        wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = words[i];
            tick();
        end
        n_checks++; if (wr_ready !== 1'b0) begin n_errors++; $display("FAIL full_wr_ready: got %b expected 0", wr_ready); end
        n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL full_no_overflow_yet: got %b expected 0", overflow); end
        wr_data = words[4];
        tick();
        wr_valid = 1'b0;
        n_checks++; if (overflow !== 1'b1) begin n_errors++; $display("FAIL overflow_set: got %b expected 1", overflow); end
        tick();
        n_checks++; if (overflow !== 1'b1) begin n_errors++; $display("FAIL overflow_sticky: got %b expected 1", overflow); end
        finish_load();
        n_checks++; if (prog_len !== 4'd4) begin n_errors++; $display("FAIL full_prog_len: got %0d expected 4", prog_len); end
        issue_read(3'd3);
        n_checks++; if (rd_data !== words[3] || rd_oob !== 1'b0) begin
            n_errors++; $display("FAIL full_read_addr3: got d=%h oob=%b expected d=%h oob=0", rd_data, rd_oob, words[3]);
        end
        issue_read(3'd0);
        n_checks++; if (rd_data !== words[0] || rd_oob !== 1'b0) begin
            n_errors++; $display("FAIL full_read_addr0: got d=%h oob=%b expected d=%h oob=0", rd_data, rd_oob, words[0]);
        end
    endtask

    task automatic test_simultaneous();
        start_load();
        n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL reload_clears_overflow: got %b expected 0", overflow); end
        push(13'h0111);
        wr_valid = 1'b1; wr_data = 13'h0222; load_done = 1'b1;
        tick();
        wr_valid = 1'b0; load_done = 1'b0;
        n_checks++; if (prog_len !== 4'd2 || prog_ready !== 1'b1) begin
            n_errors++; $display("FAIL done_with_write: got len=%0d ready=%b expected len=2 ready=1", prog_len, prog_ready);
        end
        issue_read(3'd1);
        n_checks++; if (rd_data !== 13'h0222 || rd_oob !== 1'b0) begin
            n_errors++; $display("FAIL done_with_write_data: got d=%h oob=%b expected d=0222 oob=0", rd_data, rd_oob);
        end
        start_load();
        push(13'h0333);
        load_start = 1'b1; load_done = 1'b1; wr_valid = 1'b1; wr_data = 13'h0444;
        tick();
        load_start = 1'b0; load_done = 1'b0; wr_valid = 1'b0;
        n_checks++; if (dbg_state !== ST_LOAD || prog_len !== 4'd0 || wr_ready !== 1'b1) begin
            n_errors++; $display("FAIL start_priority: got state=%0d len=%0d wr_ready=%b expected state=1 len=0 wr_ready=1", dbg_state, prog_len, wr_ready);
        end
        finish_load();
        n_checks++; if (prog_len !== 4'd0) begin n_errors++; $display("FAIL start_priority_no_write: got len=%0d expected 0", prog_len); end
        issue_read(3'd0);
        n_checks++; if (rd_oob !== 1'b1 || rd_data !== HALT) begin
            n_errors++; $display("FAIL empty_prog_read: got d=%h oob=%b expected d=%h oob=1", rd_data, rd_oob, HALT);
        end
    endtask

    task automatic test_reload();
        start_load();
        push(13'h0AAA); push(13'h0BBB); push(13'h0CCC);
        finish_load();
        n_checks++; if (prog_len !== 4'd3) begin n_errors++; $display("FAIL reload_first_len: got %0d expected 3", prog_len); end
        start_load();
        n_checks++; if (prog_ready !== 1'b0 || prog_len !== 4'd0) begin
            n_errors++; $display("FAIL reload_invalidate: got ready=%b len=%0d expected ready=0 len=0", prog_ready, prog_len);
        end
        push(13'h1F0F);
        finish_load();
        n_checks++; if (prog_len !== 4'd1) begin n_errors++; $display("FAIL reload_len: got %0d expected 1", prog_len); end
        issue_read(3'd2);
        n_checks++; if (rd_oob !== 1'b1 || rd_data !== HALT) begin
            n_errors++; $display("FAIL reload_stale_read: got d=%h oob=%b expected d=%h oob=1", rd_data, rd_oob, HALT);
        end
        issue_read(3'd0);
        n_checks++; if (rd_oob !== 1'b0 || rd_data !== 13'h1F0F) begin
            n_errors++; $display("FAIL reload_new_read: got d=%h oob=%b expected d=1f0f oob=0", rd_data, rd_oob);
        end
    endtask

    task automatic test_reset_midload();
        start_load();
        for (int i = 0; i < 5; i++) push(13'(16'h0050 + i));
        n_checks++; if (overflow !== 1'b1) begin n_errors++; $display("FAIL midload_overflow_pre: got %b expected 1", overflow); end
        rst = 1'b1; load_done = 1'b1;
        tick();
        rst = 1'b0; load_done = 1'b0;
        n_checks++; if (dbg_state !== ST_IDLE || prog_len !== 4'd0 || overflow !== 1'b0 || wr_ready !== 1'b0) begin
            n_errors++; $display("FAIL midload_reset: got state=%0d len=%0d ovf=%b wr_ready=%b expected 0/0/0/0", dbg_state, prog_len, overflow, wr_ready);
        end
        issue_read(3'd0);
        n_checks++; if (rd_oob !== 1'b1 || rd_data !== HALT) begin
            n_errors++; $display("FAIL midload_read: got d=%h oob=%b expected d=%h oob=1", rd_data, rd_oob, HALT);
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_idle_read();
        test_load_read();
        test_overflow();
        test_simultaneous();
        test_reload();
        test_reset_midload();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
